mips_load_store_unit: RTL and testbench

Load/store unit between the MIPS execute stage and the byte-addressed `mips_memory` block. It accepts one load or store request at a time and checks alignment. It drives the memory's word-aligned address, byte enables and lane-placed write data, then extracts, sign/zero-extends or merges (LWL/LWR) the returned word into a single-cycle response.

---
 rtl/mips_load_store_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// Load/store unit between the MIPS execute stage and a byte-addressed memory.
// Accepts one request at a time. It checks alignment and drives word-aligned
// memory strobes with lane-placed store data. Returned words are turned into
// a one-cycle response: byte/half extraction, sign/zero extension, or the
// LWL/LWR merge with the old rt value.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, and req_valid is ignored everywhere else.
// The response is a single-cycle resp_valid pulse with no backpressure.
// resp_rdata/resp_err are meaningful only while resp_valid is high.
module mips_load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  // Opcode encodings; store SB/SH/SW share the LB/LH/LW codes.
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LWL = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rt_old_q, rt_old_d;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic        mem_read_en_q, mem_read_en_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;

  logic        req_illegal;
  logic        req_misalign;
  logic [4:0]  st_shift;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  logic [4:0]  ld_shl;
  logic [4:0]  ld_shr;
  logic [31:0] ld_right;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  // Classify the incoming request as illegal or misaligned
  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    if (req_store) begin
      case (req_op)
        OP_LB:   req_misalign = 1'b0;
        OP_LH:   req_misalign = req_addr[0];
        OP_LW:   req_misalign = |req_addr[1:0];
        default: req_illegal  = 1'b1;
      endcase
    end else begin
      case (req_op)
        OP_LB, OP_LBU, OP_LWL, OP_LWR: req_misalign = 1'b0;
        OP_LH, OP_LHU:                 req_misalign = req_addr[0];
        OP_LW:                         req_misalign = |req_addr[1:0];
        default:                       req_illegal  = 1'b1;
      endcase
    end
  end

  // Store lane placement: write lane k lives on bits [8k+7:8k]; data is big-endian
  always_comb begin
    st_shift = {req_addr[1:0], 3'b000};
    case (req_op)
      OP_LB: begin
        st_be   = 4'b0001 << req_addr[1:0];
        st_data = {24'h0, req_wdata[7:0]} << st_shift;
      end
      OP_LH: begin
        st_be   = 4'b0011 << req_addr[1:0];
        st_data = {16'h0, req_wdata[7:0], req_wdata[15:8]} << st_shift;
      end
      default: begin
        st_be   = 4'b1111;
        st_data = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
      end
    endcase
  end

  // Load extraction from the big-endian read word (offset 0 is the MSB)
  always_comb begin
    ld_shl   = {off_q, 3'b000};
    ld_shr   = {~off_q, 3'b000};
    ld_right = mem_data_out >> ld_shr;
    ld_half  = off_q[1] ? mem_data_out[15:0] : mem_data_out[31:16];
    case (op_q)
      OP_LB:   ld_result = {{24{ld_right[7]}}, ld_right[7:0]};
      OP_LBU:  ld_result = {24'h0, ld_right[7:0]};
      OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_result = {16'h0, ld_half};
      OP_LW:   ld_result = mem_data_out;
      OP_LWL:  ld_result = (mem_data_out << ld_shl) |
                           (rt_old_q & ((32'h1 << ld_shl) - 32'h1));
      OP_LWR:  ld_result = ld_right | (rt_old_q & ~(32'hFFFF_FFFF >> ld_shr));
      default: ld_result = 32'h0;
    endcase
  end

  // Next-state and registered-output logic; strobes are single-cycle in ISSUE
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    op_d          = op_q;
    off_d         = off_q;
    rt_old_d      = rt_old_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    mem_address_d = mem_address_q;
    mem_wr_en_d   = 1'b0;
    mem_read_en_d = 1'b0;
    mem_byte_en_d = 4'b0000;
    mem_data_in_d = mem_data_in_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          op_d     = req_op;
          off_d    = req_addr[1:0];
          rt_old_d = req_rt_old;
          if (req_illegal || req_misalign) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d       = S_ISSUE;
            mem_address_d = {req_addr[31:2], 2'b00};
            if (req_store) begin
              mem_wr_en_d   = 1'b1;
              mem_byte_en_d = st_be;
              mem_data_in_d = st_data;
            end else begin
              mem_read_en_d = 1'b1;
              mem_byte_en_d = 4'b1111;
            end
          end
        end
      end
      S_ISSUE: begin
        if (store_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = ld_result;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      store_q       <= 1'b0;
      op_q          <= 3'b000;
      off_q         <= 2'b00;
      rt_old_q      <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      resp_err_q    <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wr_en_q   <= 1'b0;
      mem_read_en_q <= 1'b0;
      mem_byte_en_q <= 4'b0000;
      mem_data_in_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      op_q          <= op_d;
      off_q         <= off_d;
      rt_old_q      <= rt_old_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_address_q <= mem_address_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_read_en_q <= mem_read_en_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_read_en = mem_read_en_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed testbench for mips_load_store_unit with a byte-array memory model
// and a response scoreboard (expected {err, rdata} plus expected latency).
module tb_mips_load_store_unit;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LWL = 3'b010;
  localparam logic [2:0] OP_LW  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWR = 3'b110;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_rt_old;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic        mem_read_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;

  logic [32:0] exp_q[$];
  int          lat_q[$];
  int          pend_acc[$];
  int          acc_log[$];

  logic [7:0]  mem_b [0:1023];

  mips_load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rt_old   (req_rt_old),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_read_en  (mem_read_en),
    .mem_byte_en  (mem_byte_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write lanes little-placed, read word big-endian, registered read
  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_byte_en[k]) mem_b[mem_address[9:0] + 10'(k)] <= mem_data_in[8*k +: 8];
    end
    if (mem_read_en)
      mem_data_out <= {mem_b[mem_address[9:0]],         mem_b[mem_address[9:0] + 10'd1],
                       mem_b[mem_address[9:0] + 10'd2], mem_b[mem_address[9:0] + 10'd3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: logs accepts, counts strobes, pops and compares responses
  always @(negedge clk) begin
    if (mem_read_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
    if (rst_n && req_valid && req_ready) begin
      pend_acc.push_back(cyc + 1);
      acc_log.push_back(cyc + 1);
    end
    if (resp_valid) begin
      resp_cnt++;
      check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0 && lat_q.size() != 0 && pend_acc.size() != 0) begin
        logic [32:0] e;
        int          l;
        int          a;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        a = pend_acc.pop_front();
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_err", 32'(resp_err), 32'(e[32]));
        check("resp_latency", 32'(cyc - a + 1), 32'(l));
      end
    end
  end

  // Driver: wait for ready, present one request for one edge; returns in cycle 1
  task automatic send(input logic st, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rt,
                      input logic e, input logic [31:0] rd, input int lat);
    int w;
    w = 0;
    @(posedge clk); #1;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_rt_old = rt;
    exp_q.push_back({e, rd});
    lat_q.push_back(lat);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("resp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt,
                      input logic [31:0] rd);
    send(1'b0, op, addr, 32'h0, rt, 1'b0, rd, 3);
    wait_done();
  endtask

  initial begin
    int rd0;
    int wr0;
    int r0;
    int n_acc;
    int base;

    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    mem_b[256] = 8'h80;
    mem_b[257] = 8'h12;
    mem_b[258] = 8'h34;
    mem_b[259] = 8'h56;
    mem_data_out = 32'h0;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_op     = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rt_old = 32'h0;

    // Reset values
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_read_en", 32'(mem_read_en), 32'd0);
    check("rst_byte_en", 32'(mem_byte_en), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_address", mem_address, 32'h0);
    check("rst_data_in", mem_data_in, 32'h0);
    #20;
    rst_n = 1'b1;

    // Basic loads from 0x100 = 80 12 34 56
    load(OP_LB,  32'h100, 32'h0, 32'hFFFF_FF80);
    load(OP_LBU, 32'h100, 32'h0, 32'h0000_0080);
    load(OP_LH,  32'h102, 32'h0, 32'h0000_3456);
    load(OP_LW,  32'h100, 32'h0, 32'h8012_3456);
    load(OP_LH,  32'h100, 32'h0, 32'hFFFF_8012);
    load(OP_LHU, 32'h100, 32'h0, 32'h0000_8012);
    load(OP_LB,  32'h103, 32'h0, 32'h0000_0056);

    // SB lane placement, then read back
    send(1'b1, OP_LB, 32'h101, 32'h0000_00AA, 32'h0, 1'b0, 32'h0, 2);
    check("sb_address", mem_address, 32'h100);
    check("sb_byte_en", 32'(mem_byte_en), 32'h2);
    check("sb_lane1", 32'(mem_data_in[15:8]), 32'hAA);
    check("sb_wr_en", 32'(mem_wr_en), 32'd1);
    check("sb_read_en", 32'(mem_read_en), 32'd0);
    wait_done();
    load(OP_LW, 32'h100, 32'h0, 32'h80AA_3456);
    send(1'b1, OP_LB, 32'h101, 32'h0000_0012, 32'h0, 1'b0, 32'h0, 2);
    wait_done();

    // SH and SW lanes
    send(1'b1, OP_LH, 32'h102, 32'h0000_3456, 32'h0, 1'b0, 32'h0, 2);
    check("sh_byte_en", 32'(mem_byte_en), 32'hC);
    check("sh_lanes", 32'(mem_data_in[31:16]), 32'h5634);
    wait_done();
    send(1'b1, OP_LW, 32'h104, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 2);
    check("sw_address", mem_address, 32'h104);
    check("sw_byte_en", 32'(mem_byte_en), 32'hF);
    check("sw_data_in", mem_data_in, 32'h0DF0_FECA);
    wait_done();
    load(OP_LW,  32'h104, 32'h0, 32'hCAFE_F00D);
    load(OP_LHU, 32'h106, 32'h0, 32'h0000_F00D);
    load(OP_LB,  32'h107, 32'h0, 32'h0000_000D);
    load(OP_LW,  32'h100, 32'h0, 32'h8012_3456);

    // Error responses: no memory strobes
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    send(1'b0, OP_LW, 32'h102, 32'h0, 32'h0, 1'b1, 32'h0, 1);
    wait_done();
    send(1'b1, OP_LH, 32'h103, 32'h1234, 32'h0, 1'b1, 32'h0, 1);
    wait_done();
    send(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0, 1);
    wait_done();
    send(1'b1, OP_LWL, 32'h100, 32'h55, 32'h0, 1'b1, 32'h0, 1);
    wait_done();
    send(1'b1, OP_LW, 32'h101, 32'h55, 32'h0, 1'b1, 32'h0, 1);
    wait_done();
    check("err_no_read", 32'(rd_cnt - rd0), 32'd0);
    check("err_no_write", 32'(wr_cnt - wr0), 32'd0);

    // LWL / LWR merges with rt_old = DEADBEEF
    load(OP_LWL, 32'h101, 32'hDEAD_BEEF, 32'h1234_56EF);
    load(OP_LWR, 32'h101, 32'hDEAD_BEEF, 32'hDEAD_8012);
    load(OP_LWR, 32'h103, 32'hDEAD_BEEF, 32'h8012_3456);
    load(OP_LWL, 32'h100, 32'hDEAD_BEEF, 32'h8012_3456);
    load(OP_LWR, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BE80);
    load(OP_LWL, 32'h103, 32'hDEAD_BEEF, 32'h56AD_BEEF);

    // Async reset in CAPTURE of an LW abandons the access
    send(1'b0, OP_LW, 32'h104, 32'h0, 32'h0, 1'b0, 32'hCAFE_F00D, 3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    pend_acc.delete();
    r0 = resp_cnt;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_rdata", resp_rdata, 32'h0);
    check("arst_address", mem_address, 32'h0);
    check("arst_data_in", mem_data_in, 32'h0);
    check("arst_strobes", {29'h0, mem_wr_en, mem_read_en, |mem_byte_en}, 32'h0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("arst_no_resp", 32'(resp_cnt - r0), 32'd0);
    #1;
    check("arst_ready_after", 32'(req_ready), 32'd1);

    // Back-to-back loads with req_valid held high; op garbage while busy
    base = acc_log.size();
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 3; c++) begin
      @(posedge clk); #1;
      req_store  = 1'b0;
      req_addr   = 32'h100;
      req_rt_old = 32'h0;
      req_valid  = 1'b1;
      if (req_ready) begin
        req_op = OP_LW;
        exp_q.push_back({1'b0, 32'h8012_3456});
        lat_q.push_back(3);
        n_acc++;
      end else begin
        req_op = 3'(3'b111 - 3'($urandom_range(0, 1)));
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done();
    check("b2b_accepts", 32'(acc_log.size() - base), 32'd3);
    if (acc_log.size() - base == 3) begin
      check("b2b_gap1", 32'(acc_log[base + 1] - acc_log[base]), 32'd4);
      check("b2b_gap2", 32'(acc_log[base + 2] - acc_log[base + 1]), 32'd4);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
